mdu_unit: RTL
=============

# mdu_unit

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the E stage next to the ALU. It consumes the 4-bit MDU opcode and start strobe produced by the decoder, performs signed/unsigned multiply and divide over a configurable number of cycles, and holds the architectural HI/LO registers. It exposes a busy flag for the hazard unit and gates operation acceptance with an exception-flush input.

## Interface
- WIDTH, 32, operand and HI/LO width in bits; must be 32 for the core, other values are legal for unit test.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be at least 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be at least 1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mdu_ctrl  in  4  operation code: 0 none, 1 mfhi, 2 mflo, 3 mthi, 4 mtlo, 5 mult, 6 multu, 7 div, 8 divu; 9–15 treated as none.
- start  in  1  high with a code in 5–8 requests a multiply/divide.
- cancel  in  1  exception/eret flush; when high, no operation is accepted this cycle.
- rs_val  in  WIDTH  operand A (dividend, multiplicand, or mthi/mtlo data).
- rt_val  in  WIDTH  operand B (divisor, multiplier).
- busy  out  1  high while a multiply/divide is in flight.
- rdata  out  WIDTH  HI when mdu_ctrl=1, LO when mdu_ctrl=2, else 0; combinational from current HI/LO.
- hi  out  WIDTH  current HI register, for debug.
- lo  out  WIDTH  current LO register, for debug.

## Operation
- There are two states, IDLE and BUSY.
  - IDLE→BUSY on a clock edge where busy=0, cancel=0, start=1 and mdu_ctrl∈{5,6,7,8}.
  - BUSY→IDLE when the countdown reaches its end.
- On acceptance:
  - Latch the operation type and operands, and compute or latch the pending HI/LO result.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- mult: {HI,LO} = signed(rs) × signed(rt), full 2·WIDTH product. multu is the same with both operands unsigned.
- div: LO = quotient truncated toward zero; HI = remainder, whose sign follows the dividend. divu is the same, unsigned.
- Division by zero (rt=0): HI and LO are left unchanged at completion. busy timing is identical to a normal divide.
- div of the most negative value by −1 gives LO = most negative value, HI = 0.
- mthi / mtlo:
  - When busy=0 and cancel=0, write rs_val to HI or LO at the edge.
  - Ignored when busy=1 or cancel=1.
- start or mthi/mtlo arriving while busy=1 is ignored. The hazard unit stalls on start|busy, so this case is a protocol violation but must not corrupt state.
- cancel does not abort an operation already in BUSY; it only blocks acceptance.
- mfhi/mflo have no side effects. rdata during BUSY returns the old HI/LO; the hazard unit is responsible for stalling.

## Timing
- Reset values: busy=0, HI=0, LO=0, state IDLE, counter 0; rdata=0 unless mdu_ctrl is 1 or 2 (then it shows the reset HI/LO of 0).
- Reset asserted mid-operation discards the pending result immediately, with no write to HI/LO.
- For an accept at edge t0 with latency N (MULT_CYCLES or DIV_CYCLES):
  - busy is high from just after t0 through the edge t0+N, i.e. exactly N cycles.
  - At edge t0+N, HI/LO take the result and busy falls.
- An accept is allowed at the same edge busy falls? No: busy is still 1 at that edge. The earliest next accept is edge t0+N+1.
- mthi/mtlo take effect at the edge where they are sampled (1-cycle latency), visible on rdata in the following cycle.
- When start=1 and cancel=1 in the same cycle, cancel wins: no accept, and busy stays 0.

## Test plan
- **Reset:** assert reset mid-BUSY of a div → busy=0, HI=LO=0 immediately (asynchronous); after release, mfhi gives rdata=0.
- **mult signed:** rs=0xFFFFFFFE (−2), rt=3, mdu_ctrl=5, start pulse → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **div signs:** rs=−7, rt=2, mdu_ctrl=7 → busy high 10 cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu rs=7, rt=2 → LO=3, HI=1.
- **Boundary divides:**
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - div by 0 with HI=0x11, LO=0x22 preset via mthi/mtlo → after 10 busy cycles HI=0x11, LO=0x22.
- **cancel / busy gating:**
  - start=1 with cancel=1 → busy stays 0 and HI/LO unchanged.
  - mtlo with rs=0x55 during BUSY → ignored; the final LO is the multiply result.
  - mthi 0xABCD when idle → mfhi in the next cycle gives rdata=0xABCD.
- **Back-to-back:** mult accepted at t0 and a second start held high → second accept at t0+6 (MULT_CYCLES=5); both results correct. Rerun with MULT_CYCLES=1, DIV_CYCLES=1 → busy pulses for exactly 1 cycle.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Latency: mult/multu take MULT_CYCLES and div/divu take DIV_CYCLES. busy is high for exactly that many
//   cycles after an accept. mthi/mtlo write HI/LO at the edge where they are sampled.
// Flow control: there is none. The hazard unit stalls on start|busy. start/mthi/mtlo are ignored while
//   busy or cancel is high.
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   mdu_ctrl         0 none, 1 mfhi, 2 mflo, 3 mthi, 4 mtlo, 5 mult, 6 multu, 7 div, 8 divu
//   start, cancel    request a multiply/divide; cancel blocks any acceptance this cycle
//   rs_val, rt_val   operand A (also mthi/mtlo data), operand B
//   busy             multiply/divide in flight
//   rdata            HI for mfhi, LO for mflo, else 0 (combinational)
//   hi, lo           current HI/LO for debug
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mdu_ctrl,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  localparam logic [3:0] OP_MFHI = 4'd1;
  localparam logic [3:0] OP_MFLO = 4'd2;
  localparam logic [3:0] OP_MTHI = 4'd3;
  localparam logic [3:0] OP_MTLO = 4'd4;
  localparam logic [3:0] OP_MULT = 4'd5;
  localparam logic [3:0] OP_MULTU = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  logic              is_md, is_div, signed_op, accept, mt_ok, done;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag, den, q_mag, r_mag, quot, rem;

  // Operation decode and acceptance gating.
  always_comb begin
    is_md     = (mdu_ctrl == OP_MULT) || (mdu_ctrl == OP_MULTU) ||
                (mdu_ctrl == OP_DIV)  || (mdu_ctrl == OP_DIVU);
    is_div    = (mdu_ctrl == OP_DIV) || (mdu_ctrl == OP_DIVU);
    signed_op = (mdu_ctrl == OP_MULT) || (mdu_ctrl == OP_DIV);
    accept    = (state_q == S_IDLE) && !cancel && start && is_md;
    mt_ok     = (state_q == S_IDLE) && !cancel;
    done      = (state_q == S_BUSY) && (cnt_q == CNT_ONE);
  end

  // Result is computed at acceptance and parked until the countdown ends.
  // Multiply: extend both operands to 2*WIDTH and keep the low 2*WIDTH product bits.
  // Divide: an unsigned divide on the magnitudes, followed by a sign fix-up. This makes
  // MIN / -1 fall out naturally as MIN rem 0.
  always_comb begin
    mul_a = signed_op ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
    mul_b = signed_op ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
    prod  = mul_a * mul_b;

    a_neg = signed_op && rs_val[WIDTH-1];
    b_neg = signed_op && rt_val[WIDTH-1];
    a_mag = a_neg ? -rs_val : rs_val;
    b_mag = b_neg ? -rt_val : rt_val;
    den   = (b_mag == '0) ? ONE_W : b_mag;  // divide-by-zero result is discarded anyway
    q_mag = a_mag / den;
    r_mag = a_mag % den;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (done)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_BUSY);
  end

  // Datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (accept) begin
      cnt_d     = is_div ? CNT_DIV : CNT_MULT;
      pend_hi_d = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
      pend_lo_d = is_div ? quot : prod[WIDTH-1:0];
      pend_wr_d = !(is_div && (rt_val == '0));
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - CNT_ONE;
      if (done && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
    if (mt_ok && (mdu_ctrl == OP_MTHI)) hi_d = rs_val;
    if (mt_ok && (mdu_ctrl == OP_MTLO)) lo_d = rs_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (mdu_ctrl == OP_MFHI)      rdata = hi_q;
    else if (mdu_ctrl == OP_MFLO) rdata = lo_q;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
